// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM status and memory-arbiter types
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

    typedef enum logic [1:0] {IDLE, IGNT, DGNT, ERR} arb_state_t;

    typedef enum logic {GNT_I, GNT_D} grant_t;

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// mem_watchdog: saturating stall counter that flags a RAM access exceeding TIMEOUT cycles
module mem_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic nRST,
    input  logic count_en,
    input  logic clr,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // expired looks one cycle ahead so the owner leaves on the edge that would reach TIMEOUT
    assign expired = count_en && (count >= CW'(TIMEOUT - 1));

    // Count stalled grant cycles, saturating at TIMEOUT
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (count_en && count != CW'(TIMEOUT))
            count <= count + CW'(1);
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: alternating I/D arbiter driving a single-ported RAM with a hang watchdog
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              mem_err
);

    arb_state_t state, state_next;
    grant_t     last_grant, last_next;
    ramstate_t  rs;
    logic       granted, access, expired, d_req;

    assign rs      = ramstate_t'(ramstate);
    assign granted = state == IGNT || state == DGNT;
    assign access  = rs == ACCESS;
    assign d_req   = dREN || dWEN;
    assign mem_err = state == ERR;

    mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .CLK      (CLK),
        .nRST     (nRST),
        .count_en (granted && !access),
        .clr      (!granted || access),
        .expired  (expired)
    );

    // FSM state and fairness history
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            last_grant <= GNT_I;
        end else begin
            state      <= state_next;
            last_grant <= last_next;
        end
    end

    // Arbitration, RAM drive and cache handshake; a dropped request abandons the grant silently
    always_comb begin
        state_next = state;
        last_next  = last_grant;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        case (state)
            IDLE: begin
                if (d_req && (!iREN || last_grant == GNT_I))
                    state_next = DGNT;
                else if (iREN)
                    state_next = IGNT;
            end
            IGNT: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (rs == ERROR)
                    state_next = ERR;
                else if (!iREN)
                    state_next = IDLE;
                else if (access) begin
                    iwait      = 1'b0;
                    iload      = ramload;
                    state_next = IDLE;
                    last_next  = GNT_I;
                end else if (expired)
                    state_next = ERR;
            end
            DGNT: begin
                ramaddr  = daddr;
                ramWEN   = dWEN;
                ramREN   = !dWEN;
                ramstore = dWEN ? dstore : '0;
                if (rs == ERROR)
                    state_next = ERR;
                else if (!d_req)
                    state_next = IDLE;
                else if (access) begin
                    dwait      = 1'b0;
                    dload      = dWEN ? '0 : ramload;
                    state_next = IDLE;
                    last_next  = GNT_D;
                end else if (expired)
                    state_next = ERR;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, corner sequences and model-checked random traffic for mem_arbiter
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int TMO = 8;

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] ds;
        logic [1:0]  rs;
        logic [31:0] rl;
    } in_t;

    typedef struct {
        logic        iw;
        logic        dw;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] il;
        logic [31:0] dl;
        logic        err;
    } exp_t;

    typedef struct {
        in_t  s;
        exp_t w;
    } vec_t;

    logic        CLK, nRST, iREN, dREN, dWEN, iwait, dwait, ramREN, ramWEN, mem_err;
    logic [31:0] iaddr, daddr, dstore, ramload, iload, dload, ramaddr, ramstore;
    logic [1:0]  ramstate;

    int n_vec = 0;
    int n_bad = 0;

    int m_owner;
    bit m_last_d;
    int m_stall;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    task automatic apply(input in_t x);
        iREN = x.ir; iaddr = x.ia; dREN = x.dr; dWEN = x.dw;
        daddr = x.da; dstore = x.ds; ramstate = x.rs; ramload = x.rl;
    endtask

    function automatic in_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                               input logic [31:0] da, input logic [31:0] ds, input logic [1:0] rs,
                               input logic [31:0] rl);
        in_t x;
        x.ir = ir; x.ia = ia; x.dr = dr; x.dw = dw; x.da = da; x.ds = ds; x.rs = rs; x.rl = rl;
        return x;
    endfunction

    task automatic check(input string t, input exp_t e);
        chk({t, ".iwait"}, 32'(iwait), 32'(e.iw));
        chk({t, ".dwait"}, 32'(dwait), 32'(e.dw));
        chk({t, ".ramREN"}, 32'(ramREN), 32'(e.ren));
        chk({t, ".ramWEN"}, 32'(ramWEN), 32'(e.wen));
        chk({t, ".ramaddr"}, ramaddr, e.addr);
        chk({t, ".ramstore"}, ramstore, e.store);
        chk({t, ".iload"}, iload, e.il);
        chk({t, ".dload"}, dload, e.dl);
        chk({t, ".mem_err"}, 32'(mem_err), 32'(e.err));
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference model: owner 0 = nobody, 1 = icache, 2 = dcache, 3 = trapped
    function automatic exp_t predict(input in_t x);
        exp_t e;
        logic dq;
        dq = x.dr | x.dw;
        e.iw = !(m_owner == 1 && x.ir && x.rs == ACCESS);
        e.dw = !(m_owner == 2 && dq && x.rs == ACCESS);
        e.il = e.iw ? 32'h0 : x.rl;
        e.dl = (e.dw || x.dw) ? 32'h0 : x.rl;
        e.ren = m_owner == 1 || (m_owner == 2 && !x.dw);
        e.wen = m_owner == 2 && x.dw;
        e.addr = m_owner == 1 ? x.ia : (m_owner == 2 ? x.da : 32'h0);
        e.store = (m_owner == 2 && x.dw) ? x.ds : 32'h0;
        e.err = m_owner == 3;
        return e;
    endfunction

    task automatic model_step(input in_t x);
        logic dq, rq;
        dq = x.dr | x.dw;
        if (m_owner == 0) begin
            m_stall = 0;
            if (dq && (!x.ir || !m_last_d)) m_owner = 2;
            else if (x.ir) m_owner = 1;
        end else if (m_owner != 3) begin
            rq = (m_owner == 1) ? x.ir : dq;
            if (x.rs == ERROR) m_owner = 3;
            else if (!rq) begin m_owner = 0; m_stall = 0; end
            else if (x.rs == ACCESS) begin m_last_d = (m_owner == 2); m_owner = 0; m_stall = 0; end
            else begin
                m_stall++;
                if (m_stall >= TMO) m_owner = 3;
            end
        end
    endtask

    task automatic pulse_reset();
        nRST = 1'b0;
        #1;
        nRST = 1'b1;
        m_owner = 0; m_last_d = 1'b0; m_stall = 0;
    endtask

    vec_t tbl[$];
    exp_t idle_e;
    in_t  zero_in;

    initial begin
        in_t x;
        exp_t e;
        idle_e  = '{'1, '1, '0, '0, '0, '0, '0, '0, '0};
        zero_in = mk(0, 0, 0, 0, 0, 0, FREE, 0);

        tbl.push_back('{mk(1, 32'h100, 0, 0, 0, 0, FREE, 0), idle_e});
        tbl.push_back('{mk(1, 32'h100, 0, 0, 0, 0, ACCESS, 32'h8C010004),
                        '{'0, '1, '1, '0, 32'h100, '0, 32'h8C010004, '0, '0}});
        tbl.push_back('{mk(0, 32'h100, 0, 0, 0, 0, FREE, 32'h8C010004), idle_e});
        tbl.push_back('{mk(1, 32'h104, 1, 0, 32'h200, 0, FREE, 0), idle_e});
        tbl.push_back('{mk(1, 32'h104, 1, 0, 32'h200, 0, ACCESS, 32'h11111111),
                        '{'1, '0, '1, '0, 32'h200, '0, '0, 32'h11111111, '0}});
        tbl.push_back('{mk(1, 32'h104, 1, 0, 32'h200, 0, FREE, 0), idle_e});
        tbl.push_back('{mk(1, 32'h104, 1, 0, 32'h200, 0, ACCESS, 32'h22222222),
                        '{'0, '1, '1, '0, 32'h104, '0, 32'h22222222, '0, '0}});
        tbl.push_back('{mk(1, 32'h104, 1, 0, 32'h200, 0, FREE, 0), idle_e});
        tbl.push_back('{mk(1, 32'h104, 1, 0, 32'h200, 0, ACCESS, 32'h33333333),
                        '{'1, '0, '1, '0, 32'h200, '0, '0, 32'h33333333, '0}});
        tbl.push_back('{mk(1, 32'h104, 1, 0, 32'h200, 0, FREE, 0), idle_e});
        tbl.push_back('{mk(1, 32'h104, 1, 0, 32'h200, 0, ACCESS, 32'h44444444),
                        '{'0, '1, '1, '0, 32'h104, '0, 32'h44444444, '0, '0}});
        tbl.push_back('{mk(0, 32'h104, 1, 1, 32'h200, 32'hDEADBEEF, FREE, 0), idle_e});
        for (int k = 0; k < 3; k++)
            tbl.push_back('{mk(0, 32'h104, 1, 1, 32'h200, 32'hDEADBEEF, BUSY, 32'h55555555),
                            '{'1, '1, '0, '1, 32'h200, 32'hDEADBEEF, '0, '0, '0}});
        tbl.push_back('{mk(0, 32'h104, 1, 1, 32'h200, 32'hDEADBEEF, ACCESS, 32'h55555555),
                        '{'1, '0, '0, '1, 32'h200, 32'hDEADBEEF, '0, '0, '0}});
        tbl.push_back('{zero_in, idle_e});

        // Outputs held quiet while reset is asserted, even with live requests
        nRST = 1'b0;
        apply(mk(1, 32'h100, 1, 1, 32'h200, 32'h1234, ACCESS, 32'hABCD));
        #3;
        check("reset", idle_e);
        apply(zero_in);
        #4;
        nRST = 1'b1;
        #1;

        foreach (tbl[k]) begin
            apply(tbl[k].s);
            #1;
            check($sformatf("tbl%0d", k), tbl[k].w);
            tick();
        end

        // Withdrawal: last grant becomes I, then a D grant is abandoned
        apply(mk(1, 32'h400, 0, 0, 0, 0, FREE, 0)); tick();
        apply(mk(1, 32'h400, 0, 0, 0, 0, ACCESS, 32'h77)); #1;
        chk("wd_ifetch.iwait", 32'(iwait), 0); tick();
        apply(mk(0, 0, 1, 0, 32'h300, 0, FREE, 0)); tick();
        apply(mk(0, 0, 1, 0, 32'h300, 0, BUSY, 0)); #1;
        chk("wd_busy.ramREN", 32'(ramREN), 1);
        chk("wd_busy.dwait", 32'(dwait), 1); tick();
        apply(mk(0, 0, 0, 0, 32'h300, 0, BUSY, 32'h99)); #1;
        chk("wd_drop.dwait", 32'(dwait), 1); tick();
        apply(mk(1, 32'h400, 1, 0, 32'h300, 0, FREE, 0)); #1;
        chk("wd_idle.ramREN", 32'(ramREN), 0);
        chk("wd_idle.ramWEN", 32'(ramWEN), 0);
        chk("wd_idle.dwait", 32'(dwait), 1); tick();
        apply(mk(1, 32'h400, 1, 0, 32'h300, 0, ACCESS, 32'h88)); #1;
        chk("wd_regrant.ramaddr", ramaddr, 32'h300);
        chk("wd_regrant.dwait", 32'(dwait), 0);
        chk("wd_regrant.iwait", 32'(iwait), 1); tick();
        apply(zero_in); tick();

        // Watchdog: BUSY forever traps after TMO grant cycles
        apply(mk(1, 32'h500, 0, 0, 0, 0, BUSY, 0)); tick();
        for (int k = 0; k < TMO; k++) begin
            #1;
            chk($sformatf("tmo%0d.ramREN", k), 32'(ramREN), 1);
            chk($sformatf("tmo%0d.mem_err", k), 32'(mem_err), 0);
            tick();
        end
        #1;
        check("tmo_err", '{'1, '1, '0, '0, '0, '0, '0, '0, '1});
        apply(mk(1, 32'h500, 0, 0, 0, 0, ACCESS, 32'h66)); tick();
        check("err_sticky", '{'1, '1, '0, '0, '0, '0, '0, '0, '1});
        pulse_reset();

        // ramstate ERROR while granted traps on the next edge
        apply(mk(0, 0, 1, 0, 32'h600, 0, FREE, 0)); tick();
        apply(mk(0, 0, 1, 0, 32'h600, 0, ERROR, 0)); #1;
        chk("rerr_pre.mem_err", 32'(mem_err), 0); tick();
        chk("rerr_post.mem_err", 32'(mem_err), 1);
        chk("rerr_post.ramREN", 32'(ramREN), 0);
        pulse_reset();

        // Async reset in the middle of a D write
        apply(mk(0, 0, 0, 1, 32'h700, 32'hCAFE, FREE, 0)); tick();
        apply(mk(0, 0, 0, 1, 32'h700, 32'hCAFE, BUSY, 0)); #1;
        chk("ar_pre.ramWEN", 32'(ramWEN), 1);
        nRST = 1'b0; #1;
        chk("ar_in.ramWEN", 32'(ramWEN), 0);
        chk("ar_in.ramREN", 32'(ramREN), 0);
        chk("ar_in.dwait", 32'(dwait), 1);
        chk("ar_in.mem_err", 32'(mem_err), 0);
        #1 nRST = 1'b1; #1;
        chk("ar_rel.ramWEN", 32'(ramWEN), 0); tick();
        apply(mk(0, 0, 0, 1, 32'h700, 32'hCAFE, ACCESS, 0)); #1;
        chk("ar_resume.ramWEN", 32'(ramWEN), 1);
        chk("ar_resume.dwait", 32'(dwait), 0); tick();
        apply(zero_in);

        // Random traffic against the reference model
        pulse_reset();
        for (int n = 0; n < 3000; n++) begin
            int r;
            if (m_owner == 3 && $urandom_range(3) == 0) pulse_reset();
            r = $urandom_range(99);
            x = mk($urandom_range(2) != 0, $urandom, $urandom_range(2) == 0, $urandom_range(3) == 0,
                   $urandom, $urandom, r < 1 ? ERROR : r < 45 ? BUSY : r < 60 ? FREE : ACCESS, $urandom);
            apply(x);
            #1;
            e = predict(x);
            check($sformatf("rnd%0d", n), e);
            @(posedge CLK);
            model_step(x);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Memory-side responder for the cache-to-memory interface: it services instruction-cache fetches and data-cache reads/writes against a single-ported RAM.
- Arbitrates between the two requesters and drives iwait/dwait/iload/dload back to the caches.
- Sits between the caches block and the RAM, inside the system top.
- Includes a fairness rule so instruction fetch is never starved, and a watchdog that traps a hung RAM.

Parameters:
- ADDR_W, 32, width of iaddr/daddr/ramaddr.
- DATA_W, 32, width of load/store data (word_t).
- TIMEOUT, 255, maximum cycles a grant may wait for ramstate==ACCESS before the block enters ERR.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  icache read request, held until iwait low.
- iaddr  in  ADDR_W  icache word address.
- iwait  out  1  high = icache must keep waiting.
- iload  out  DATA_W  instruction word, valid when iwait low.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  ADDR_W  dcache word address.
- dstore  in  DATA_W  dcache write data.
- dwait  out  1  high = dcache must keep waiting.
- dload  out  DATA_W  data word, valid when dwait low on a read.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- mem_err  out  1  sticky error flag.

Behaviour:
- Reset (async, nRST low): state=IDLE, last_grant=I, watchdog=0, mem_err=0.
  - Outputs during reset: iwait=1, dwait=1, iload=0, dload=0, ramREN=ramWEN=0, ramaddr=0, ramstore=0.
  - Reset asserted mid-transaction abandons it immediately; no RAM enable is held.
- FSM states: IDLE, IGNT, DGNT, ERR. The state is registered; all outputs are combinational from state and live inputs.
- IDLE:
  - No RAM enables are driven; iwait=dwait=1.
  - Next state: if only the d-request is pending -> DGNT.
  - If only iREN -> IGNT.
  - If both are pending -> DGNT, unless last_grant==D, in which case -> IGNT (alternation).
- DGNT:
  - ramaddr=daddr.
  - dWEN=1 -> ramWEN=1, ramstore=dstore, ramREN=0. dWEN has precedence if dREN and dWEN are both high.
  - Otherwise ramREN=1.
  - When ramstate==ACCESS: dwait=0 that same cycle, dload=ramload (0 on writes). Next state IDLE, last_grant<=D.
- IGNT:
  - ramaddr=iaddr, ramREN=1.
  - When ramstate==ACCESS: iwait=0, iload=ramload. Next state IDLE, last_grant<=I.
- Latency:
  - Minimum 2 cycles from a request entering IDLE to wait low: one arbitration cycle plus one RAM access cycle.
  - One bubble cycle in IDLE between back-to-back transactions.
- Request withdrawn during a grant (the granted request signal drops before ACCESS): next state IDLE, no wait-low pulse, last_grant unchanged.
- The ungranted requester's wait stays 1 throughout.
- Watchdog:
  - Counts cycles in IGNT/DGNT while ramstate!=ACCESS.
  - Clears on IDLE or on ACCESS.
  - Count reaching TIMEOUT -> ERR.
  - ramstate==ERROR while granted -> ERR immediately (next edge).
- ERR: mem_err=1, iwait=dwait=1, all RAM enables 0. The block leaves ERR only via nRST.
- iload/dload are 0 whenever the corresponding wait is 1.

Decomposition:
- Add to cpu_types_pkg:
  - arb_state_t enum {IDLE, IGNT, DGNT, ERR}.
  - grant_t enum {GNT_I, GNT_D}.
- Reuse the existing word_t and ramstate_t from cpu_types_pkg.
- One sub-module, mem_watchdog: a TIMEOUT-bounded up-counter with inputs count_en and clr, output expired.

Test Plan:
- iREN=1, iaddr=0x100; RAM returns ACCESS on the 1st grant cycle with ramload=0x8C010004 -> ramREN=1, ramaddr=0x100 at cycle 1; iwait=0 and iload=0x8C010004 at cycle 1 only; back to IDLE at cycle 2.
- iREN and dREN both high from reset release, last_grant=I -> DGNT first.
  - After the D completes (last_grant=D), the I fetch is granted next even though dREN is re-asserted, giving an alternating D,I,D,I sequence.
- dWEN=1, dREN=1, daddr=0x200, dstore=0xDEADBEEF, RAM BUSY for 3 cycles then ACCESS -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF for 4 grant cycles; dwait low only on the ACCESS cycle; dload=0.
- Grant DGNT, then dREN dropped after 1 BUSY cycle -> IDLE next edge, no dwait pulse, RAM enables deasserted.
- ramstate held BUSY with TIMEOUT=8 -> ERR after 8 grant cycles, mem_err=1, iwait=dwait=1, RAM enables 0. Separately, ramstate=ERROR -> ERR on the next edge.
- nRST pulsed low mid-DGNT (async, between edges) -> ramWEN and ramREN drop immediately, dwait=1, mem_err=0, and after release the FSM resumes from IDLE.
